// File: rtl/sfp_link_ctrl.sv
// sfp_link_ctrl: bring-up / supervision FSM for one SFP cage and its transceiver.
// Latency: sideband pins see 2 synchronizer cycles, then 1 registered FSM cycle to the outputs.
// Backpressure: none; this is pure control, the datapath simply watches link_up_o.
//
// Ports:
//   clk_i              sole clock, posedge
//   rst_i              synchronous active-high reset
//   sfp_mod_abs_i      module absent pin (async, synchronized here)
//   sfp_los_i          receiver loss of signal pin (async, synchronized here)
//   sfp_tx_fault_i     transmitter fault pin (async, synchronized here)
//   pll_lock_i         transceiver PLL lock (clk_i domain)
//   rx_sync_i          receive word alignment achieved (clk_i domain)
//   sfp_tx_disable_o   SFP TX_DISABLE, 1 = laser off
//   xcvr_rst_o         transceiver reset, active high
//   link_up_o          link usable by the datapath
//   state_o            FSM state encoding
//   link_drops_o       saturating count of LINK_UP exits (only with SFP_LINK_STATS_EN)
//
// Optional feature macro: SFP_LINK_STATS_EN adds the link_drops_o counter and port.
module sfp_link_ctrl #(
  parameter int unsigned TX_EN_WAIT   = 1024,
  parameter int unsigned RST_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOS_FILTER   = 16,
  parameter int unsigned FAULT_HOLD   = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sfp_mod_abs_i,
  input  logic       sfp_los_i,
  input  logic       sfp_tx_fault_i,
  input  logic       pll_lock_i,
  input  logic       rx_sync_i,
  output logic       sfp_tx_disable_o,
  output logic       xcvr_rst_o,
  output logic       link_up_o,
  output logic [2:0] state_o
`ifdef SFP_LINK_STATS_EN
  ,
  output logic [15:0] link_drops_o
`endif
);

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_TX_WAIT   = 3'd1,
    ST_XRST      = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_LINK_UP   = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // The shared counter only ever needs to reach (largest parameter - 1).
  localparam int unsigned MAX_AB = (TX_EN_WAIT > RST_CYCLES) ? TX_EN_WAIT : RST_CYCLES;
  localparam int unsigned MAX_CD = (LOCK_TIMEOUT > LOS_FILTER) ? LOCK_TIMEOUT : LOS_FILTER;
  localparam int unsigned MAX_AD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned MAX_N  = (MAX_AD > FAULT_HOLD) ? MAX_AD : FAULT_HOLD;
  localparam int unsigned CNT_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  // Terminal values: leaving when the counter equals N-1 means exactly N cycles in the state.
  localparam logic [CNT_W-1:0] TX_EN_LAST = CNT_W'(TX_EN_WAIT - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOS_LAST   = CNT_W'(LOS_FILTER - 1);
  localparam logic [CNT_W-1:0] FAULT_LAST = CNT_W'(FAULT_HOLD - 1);

  // Two-flop synchronizers; reset to 1 so an unknown cage looks absent/faulty until sampled.
  logic [1:0] mod_abs_sync_q;
  logic [1:0] los_sync_q;
  logic [1:0] tx_fault_sync_q;
  logic       mod_abs_s;
  logic       los_s;
  logic       tx_fault_s;

  assign mod_abs_s  = mod_abs_sync_q[1];
  assign los_s      = los_sync_q[1];
  assign tx_fault_s = tx_fault_sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mod_abs_sync_q  <= 2'b11;
      los_sync_q      <= 2'b11;
      tx_fault_sync_q <= 2'b11;
    end else begin
      mod_abs_sync_q  <= {mod_abs_sync_q[0], sfp_mod_abs_i};
      los_sync_q      <= {los_sync_q[0], sfp_los_i};
      tx_fault_sync_q <= {tx_fault_sync_q[0], sfp_tx_fault_i};
    end
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_dis_q, tx_dis_d;
  logic             xrst_q, xrst_d;
  logic             link_q, link_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);

    if (state_q == ST_DISABLED) begin
      if (!mod_abs_s) state_d = ST_TX_WAIT;
    end else if (mod_abs_s) begin
      state_d = ST_DISABLED;
    end else if (tx_fault_s && (state_q != ST_FAULT)) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_TX_WAIT:   if (cnt_q == TX_EN_LAST) state_d = ST_XRST;
        ST_XRST:      if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (pll_lock_i && rx_sync_i) state_d = ST_LINK_UP;
          else if (cnt_q == LOCK_LAST) state_d = ST_XRST;
        end
        // In LINK_UP the counter tracks the current run of LOS-high cycles.
        ST_LINK_UP: begin
          if (!pll_lock_i) state_d = ST_XRST;
          else if (!los_s) cnt_d = '0;
          else if (cnt_q == LOS_LAST) state_d = ST_XRST;
        end
        ST_FAULT:     if (cnt_q == FAULT_LAST) state_d = ST_DISABLED;
        default:      state_d = ST_DISABLED;
      endcase
    end

    if ((state_d != state_q) || (state_q == ST_DISABLED)) cnt_d = '0;

    // Outputs are decoded from the next state so they toggle on the same edge as the state.
    tx_dis_d = (state_d == ST_DISABLED) || (state_d == ST_FAULT);
    xrst_d   = (state_d == ST_DISABLED) || (state_d == ST_TX_WAIT) ||
               (state_d == ST_XRST)     || (state_d == ST_FAULT);
    link_d   = (state_d == ST_LINK_UP);
  end

`ifdef SFP_LINK_STATS_EN
  logic [15:0] drops_q, drops_d;

  always_comb begin
    drops_d = drops_q;
    if ((state_q == ST_LINK_UP) && (state_d != ST_LINK_UP) && (drops_q != 16'hFFFF))
      drops_d = drops_q + 16'd1;
  end

  assign link_drops_o = drops_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_DISABLED;
      cnt_q    <= '0;
      tx_dis_q <= 1'b1;
      xrst_q   <= 1'b1;
      link_q   <= 1'b0;
`ifdef SFP_LINK_STATS_EN
      drops_q  <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_dis_q <= tx_dis_d;
      xrst_q   <= xrst_d;
      link_q   <= link_d;
`ifdef SFP_LINK_STATS_EN
      drops_q  <= drops_d;
`endif
    end
  end

  assign sfp_tx_disable_o = tx_dis_q;
  assign xcvr_rst_o       = xrst_q;
  assign link_up_o        = link_q;
  assign state_o          = state_q;

endmodule
